// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command framing stage: RX framing states,
// command opcodes understood by cmd_cfg and the positive-acknowledge response.
package uart_cmd_pkg;

    typedef enum logic [1:0] {
        WAIT_CMD = 2'd0,
        WAIT_HI  = 2'd1,
        WAIT_LO  = 2'd2
    } rx_state_e;

    // Opcodes shared with cmd_cfg; the framing stage passes them through untouched.
    localparam logic [7:0] CMD_CFG_GAIN   = 8'h01;
    localparam logic [7:0] CMD_CFG_OFFSET = 8'h02;
    localparam logic [7:0] CMD_CFG_THRESH = 8'h03;
    localparam logic [7:0] CMD_CFG_MODE   = 8'h04;
    localparam logic [7:0] CMD_CAL_START  = 8'h05;
    localparam logic [7:0] CMD_READ_STAT  = 8'h06;
    localparam logic [7:0] CMD_WRITE_REG  = 8'h07;
    localparam logic [7:0] CMD_NOP        = 8'h08;

    localparam logic [7:0] POS_ACK = 8'hA5;

endpackage

// File: rtl/uart_cmd_if.sv
// Signal bundle between the UART byte transceiver / cmd_cfg and the framing stage.
// The framing stage uses the slave modport; its environment uses master.
interface uart_cmd_if;

    logic        rx_rdy;
    logic [7:0]  rx_data;
    logic        clr_rx_rdy;
    logic        tx_done;
    logic        trmt;
    logic [7:0]  tx_data;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [7:0]  resp;
    logic        cmd_rdy;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        resp_sent;
    logic        frm_err;

    modport slave (
        input  rx_rdy, rx_data, tx_done, clr_cmd_rdy, send_resp, resp,
        output clr_rx_rdy, trmt, tx_data, cmd_rdy, cmd, data, resp_sent, frm_err
    );

    modport master (
        output rx_rdy, rx_data, tx_done, clr_cmd_rdy, send_resp, resp,
        input  clr_rx_rdy, trmt, tx_data, cmd_rdy, cmd, data, resp_sent, frm_err
    );

endinterface

// File: rtl/uart_resp_q.sv
// Response transmit path: launches a response byte on an idle transmitter or
// parks it in a one-entry pending register (newest wins) until tx_done.
module uart_resp_q (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       send_resp,
    input  logic [7:0] resp,
    input  logic       tx_done,
    output logic       trmt,
    output logic [7:0] tx_data,
    output logic       resp_sent
);

    logic       busy;
    logic       pend_vld;
    logic [7:0] pend_data;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; the default trmt<=0 makes it a one-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            pend_vld  <= 1'b0;
            pend_data <= 8'h00;
            trmt      <= 1'b0;
            tx_data   <= 8'h00;
            resp_sent <= 1'b0;
        end else begin
            trmt      <= 1'b0;
            resp_sent <= tx_done;
            if (tx_done && pend_vld) begin
                // Older pending byte goes first; a simultaneous new one takes its slot.
                trmt     <= 1'b1;
                tx_data  <= pend_data;
                pend_vld <= send_resp;
                if (send_resp) pend_data <= resp;
            end else if (send_resp && (!busy || tx_done)) begin
                trmt    <= 1'b1;
                tx_data <= resp;
                busy    <= 1'b1;
            end else if (send_resp) begin
                pend_vld  <= 1'b1;
                pend_data <= resp;
            end else if (tx_done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/uart_cmd_wrapper.sv
// Frames 3-byte remote commands (opcode, data hi, data lo) and returns cmd_cfg responses.
// Optional inter-byte timeout that drops partial frames: define CMD_TIMEOUT_EN.
module uart_cmd_wrapper
    import uart_cmd_pkg::*;
#(
    parameter int TMO_W = 20
) (
    input logic       clk,
    input logic       rst_n,
    uart_cmd_if.slave bus
);

    if (TMO_W < 2) begin : g_bad_tmo_w
        $error("TMO_W must be at least 2");
    end

    rx_state_e   state;
    logic [7:0]  cmd_q;
    logic [15:0] data_q;
    logic        cmd_rdy_q;
    logic        tmo_hit;

    // Every offered byte is taken, so the acknowledge is the request itself.
    assign bus.clr_rx_rdy = bus.rx_rdy;

`ifdef CMD_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_cnt;
    logic             frm_err_q;

    // A byte arriving in the saturation cycle wins over the timeout.
    assign tmo_hit = (state != WAIT_CMD) && (&tmo_cnt) && !bus.rx_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt   <= '0;
            frm_err_q <= 1'b0;
        end else begin
            frm_err_q <= tmo_hit;
            if (bus.rx_rdy || state == WAIT_CMD || tmo_hit) tmo_cnt <= '0;
            else tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign bus.frm_err = frm_err_q;
`else
    assign tmo_hit     = 1'b0;
    assign bus.frm_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= WAIT_CMD;
            cmd_q     <= 8'h00;
            data_q    <= 16'h0000;
            cmd_rdy_q <= 1'b0;
        end else begin
            // NOTE: the frame-complete set below is written later in this block,
            // so it overrides a same-cycle clr_cmd_rdy (last NBA wins).
            if (bus.clr_cmd_rdy) cmd_rdy_q <= 1'b0;
            if (bus.rx_rdy) begin
                unique case (state)
                    WAIT_CMD: begin
                        cmd_q     <= bus.rx_data;
                        cmd_rdy_q <= 1'b0;
                        state     <= WAIT_HI;
                    end
                    WAIT_HI: begin
                        data_q[15:8] <= bus.rx_data;
                        state        <= WAIT_LO;
                    end
                    WAIT_LO: begin
                        data_q[7:0] <= bus.rx_data;
                        cmd_rdy_q   <= 1'b1;
                        state       <= WAIT_CMD;
                    end
                    default: state <= WAIT_CMD;
                endcase
            end else if (tmo_hit) begin
                // Partial cmd/data values are left as they are.
                state <= WAIT_CMD;
            end
        end
    end

    assign bus.cmd     = cmd_q;
    assign bus.data    = data_q;
    assign bus.cmd_rdy = cmd_rdy_q;

    uart_resp_q u_resp_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .send_resp (bus.send_resp),
        .resp      (bus.resp),
        .tx_done   (bus.tx_done),
        .trmt      (bus.trmt),
        .tx_data   (bus.tx_data),
        .resp_sent (bus.resp_sent)
    );

endmodule
